// File: rtl/cpa16_accum_ctrl.sv
// cpa16_accum_ctrl: valid/ready front-end that accumulates a programmed number of
// unsigned operands through an external combinational CPA16 prefix adder.
// The accumulator and operand registers drive the adder directly; its Sum is
// captured back into the accumulator during the ADD state.

module cpa16_accum_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] cpa_a,
    output logic [WIDTH-1:0] cpa_b,
    input  logic [WIDTH-1:0] cpa_sum,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAdd,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] remaining_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // Job sequencing, datapath capture and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            opnd_q      <= '0;
            remaining_q <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (num_ops != '0) begin
                            remaining_q <= num_ops;
                            in_ready_q  <= 1'b1;
                            state_q     <= StWait;
                        end else begin
                            // Empty job: report a zero total straight away.
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StWait: begin
                    if (in_valid) begin
                        opnd_q     <= in_data;
                        in_ready_q <= 1'b0;
                        state_q    <= StAdd;
                    end
                end
                StAdd: begin
                    acc_q       <= cpa_sum;
                    // CPA16 has no carry-out; a wrapped sum is smaller than either addend.
                    ovf_q       <= ovf_q | (cpa_sum < acc_q);
                    remaining_q <= remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= StWait;
                    end
                end
                StDone: begin
                    // start is deliberately not examined here, even alongside out_ready.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers; no input reaches an output combinationally.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        busy      = busy_q;
        cpa_a     = acc_q;
        cpa_b     = opnd_q;
        out_sum   = acc_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: doc/cpa16_accum_ctrl.md
Name: cpa16_accum_ctrl

Overview:
- Sequential front-end that drives the combinational 16-bit prefix adder CPA16 (ports A, B, Sum) from a valid/ready operand stream.
- Accumulates a programmed count of 16-bit unsigned operands through CPA16 and presents the modulo-2^16 total plus a sticky carry-out flag on a valid/ready result port.
- Owns the registered CPA16 inputs and captures Sum; CPA16 is instantiated alongside it at the next level up.

Parameters:
- WIDTH, 16, operand/accumulator width; must match CPA16 width.
- CNT_W, 8, width of operand-count field; max operands per job = 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  job start pulse; sampled only in IDLE.
- num_ops  input  CNT_W  operand count for the job; sampled with start.
- in_valid  input  1  operand valid.
- in_data  input  WIDTH  operand.
- in_ready  output  1  operand accepted when in_valid&in_ready at clk edge.
- cpa_a  output  WIDTH  to CPA16 A; always the accumulator register.
- cpa_b  output  WIDTH  to CPA16 B; always the operand register.
- cpa_sum  input  WIDTH  from CPA16 Sum (combinational, same cycle).
- out_valid  output  1  result valid.
- out_sum  output  WIDTH  accumulated total mod 2^WIDTH.
- out_ovf  output  1  sticky: set if any addition in the job carried out.
- out_ready  input  1  result consumed when out_valid&out_ready at clk edge.
- busy  output  1  high in any state except IDLE.

Behaviour:
- States: IDLE, WAIT, ADD, DONE. All registered; outputs decoded from state/registers only (no input-to-output combinational paths other than via CPA16).
- Reset (rst=1 at edge, any state, including mid-job): state=IDLE; acc, opnd, remaining, ovf cleared to 0. Hence in_ready=0, out_valid=0, out_sum=0, out_ovf=0, cpa_a=0, cpa_b=0, busy=0. Any in-flight operand or unread result is discarded.
- IDLE: in_ready=0. On start=1:
  - If num_ops!=0: acc=0, ovf=0, remaining=num_ops, go to WAIT.
  - If num_ops=0: acc=0, ovf=0, go to DONE.
- WAIT: in_ready=1. On in_valid: opnd=in_data, go to ADD. Otherwise hold (gaps of any length allowed).
- ADD: in_ready=0; CPA16 evaluates cpa_a+cpa_b.
  - Next state: acc=cpa_sum.
  - ovf |= (cpa_sum < cpa_a), unsigned compare, i.e. carry-out reconstructed since CPA16 has none.
  - remaining decrements by 1.
  - If remaining was 1, go to DONE; else go to WAIT.
- DONE: out_valid=1, out_sum=acc, out_ovf=ovf, both held stable while out_ready=0. On out_ready=1, go to IDLE. acc and ovf are retained until the next start.
- Timing:
  - Throughput is one operand per 2 cycles.
  - A job of N operands with in_valid held high: start at edge 0, out_valid first high after edge 2N+1.
  - num_ops=0: out_valid high after edge 1.
- start is ignored outside IDLE. start and out_ready coinciding in DONE returns to IDLE only; start is not captured.
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Test Plan:
- start, num_ops=3, operands 1,2,3 with in_valid held -> out_sum=6, out_ovf=0, out_valid rises after edge 7.
- num_ops=2, operands 65535 then 1 -> out_sum=0, out_ovf=1. Follow with a new job 5,5 -> out_sum=10, out_ovf=0 (sticky flag cleared per job).
- num_ops=255, every operand 0x0101, random in_valid gaps, out_ready held low for 10 cycles in DONE -> out_sum=0xFFFF, out_ovf=0; result stable until out_ready. Check in_ready is never high outside WAIT.
- num_ops=0 -> out_valid after one cycle, out_sum=0, out_ovf=0. Pulse start repeatedly during the job -> ignored, count unchanged.
- rst asserted after 2 of 4 operands -> next cycle all outputs 0, busy=0. New job 7,8 -> out_sum=15.
- Self-check every ADD cycle: cpa_sum equals (cpa_a+cpa_b) mod 2^16 with real CPA16 instantiated. Sweep cpa_a=65535, cpa_b=0..65535 -> carry flag set exactly when cpa_b!=0.
